// File: rtl/sum_group_pkg.sv
// Shared state encoding and default sizing for the group source and its buffer.
package sum_group_pkg;

  localparam int GROUP_LEN_DEF = 128;
  localparam int DATA_W_DEF    = 8;
  localparam int SUM_W_DEF     = 17;
  localparam int TIMEOUT_DEF   = 255;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_START,
    S_STREAM,
    S_WAIT
  } state_e;

endpackage

// File: rtl/sum_group_buffer.sv
// One-group byte store: simple dual-port RAM with a registered read that
// returns zero whenever no read is issued, so idle cycles drive zeros.
module sum_group_buffer #(
  parameter int DEPTH  = 128,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic                     rd_en_i,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output logic [DATA_W-1:0]        rd_data_o
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // NOTE: the array itself is never reset so it can map onto block RAM;
  // only the output register clears, which is all the stream needs.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          rd_data_q <= '0;
    else if (rd_en_i) rd_data_q <= mem[rd_addr_i];
    else              rd_data_q <= '0;
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sum_group_source.sv
// Buffers one group of bytes, replays it to the group summer behind a start
// pulse, then captures the summer's result or abandons the group on timeout.
module sum_group_source
  import sum_group_pkg::*;
#(
  parameter int GROUP_LEN = GROUP_LEN_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int SUM_W     = SUM_W_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              data_start,
  input  logic [SUM_W-1:0]  sum_in,
  input  logic              sum_enable,
  output logic [SUM_W-1:0]  group_sum,
  output logic [SUM_W-1:0]  result_sum,
  output logic              result_valid,
  output logic              timeout_err,
  output logic              busy
);

  localparam int AW = $clog2(GROUP_LEN);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_e           state_q, state_d;
  logic [AW-1:0]    wr_idx_q, wr_idx_d;
  logic [AW-1:0]    rd_idx_q, rd_idx_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [SUM_W-1:0] group_sum_q, group_sum_d;
  logic [SUM_W-1:0] result_sum_q, result_sum_d;
  logic             result_valid_q, result_valid_d;
  logic             timeout_err_q, timeout_err_d;
  logic             data_start_q, data_start_d;
  logic             wr_en, rd_en;
  logic [AW-1:0]    rd_addr;

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    wr_idx_d       = wr_idx_q;
    rd_idx_d       = rd_idx_q;
    tmo_d          = tmo_q;
    group_sum_d    = group_sum_q;
    result_sum_d   = result_sum_q;
    result_valid_d = 1'b0;
    timeout_err_d  = 1'b0;
    wr_en          = 1'b0;
    rd_en          = 1'b0;
    rd_addr        = rd_idx_q;

    case (state_q)
      S_IDLE: state_d = S_FILL;

      S_FILL: begin
        if (in_valid) begin
          wr_en       = 1'b1;
          wr_idx_d    = wr_idx_q + AW'(1);
          group_sum_d = (wr_idx_q == '0) ? SUM_W'(in_data)
                                         : group_sum_q + SUM_W'(in_data);
          if (wr_idx_q == AW'(GROUP_LEN - 1)) state_d = S_START;
        end
      end

      // Byte 0 is read here so it appears on data_out in the first STREAM cycle.
      S_START: begin
        rd_en    = 1'b1;
        rd_addr  = '0;
        rd_idx_d = AW'(1);
        state_d  = S_STREAM;
      end

      // rd_idx wraps to 0 once the last read is issued; that marks the final byte.
      S_STREAM: begin
        if (rd_idx_q != '0) begin
          rd_en    = 1'b1;
          rd_idx_d = rd_idx_q + AW'(1);
        end else begin
          tmo_d   = '0;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (sum_enable) begin
          result_sum_d   = sum_in;
          result_valid_d = 1'b1;
          state_d        = S_FILL;
        end else if (tmo_q == TW'(TIMEOUT)) begin
          timeout_err_d = 1'b1;
          state_d       = S_FILL;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    data_start_d = (state_d == S_START);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q        <= S_IDLE;
      wr_idx_q       <= '0;
      rd_idx_q       <= '0;
      tmo_q          <= '0;
      group_sum_q    <= '0;
      result_sum_q   <= '0;
      result_valid_q <= 1'b0;
      timeout_err_q  <= 1'b0;
      data_start_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_idx_q       <= wr_idx_d;
      rd_idx_q       <= rd_idx_d;
      tmo_q          <= tmo_d;
      group_sum_q    <= group_sum_d;
      result_sum_q   <= result_sum_d;
      result_valid_q <= result_valid_d;
      timeout_err_q  <= timeout_err_d;
      data_start_q   <= data_start_d;
    end
  end

  sum_group_buffer #(
    .DEPTH (GROUP_LEN),
    .DATA_W(DATA_W)
  ) u_buffer (
    .clk      (CLK),
    .rst      (RST),
    .wr_en_i  (wr_en),
    .wr_addr_i(wr_idx_q),
    .wr_data_i(in_data),
    .rd_en_i  (rd_en),
    .rd_addr_i(rd_addr),
    .rd_data_o(data_out)
  );

  assign in_ready     = (state_q == S_FILL);
  assign busy         = (state_q == S_START) || (state_q == S_STREAM) || (state_q == S_WAIT);
  assign data_start   = data_start_q;
  assign group_sum    = group_sum_q;
  assign result_sum   = result_sum_q;
  assign result_valid = result_valid_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_sum_group_source.sv
// Self-checking bench for sum_group_source: table of group scenarios plus a
// mid-stream reset sequence, checked against a cycle-timing model of the group protocol.
module tb_sum_group_source;

  localparam int GL      = 128;
  localparam int DATA_W  = 8;
  localparam int SUM_W   = 17;
  localparam int TIMEOUT = 255;
  localparam int NVEC    = 10;

  localparam int P_RAMP = 0, P_FF = 1, P_RAND = 2;

  typedef struct {
    int             pat;       // byte pattern
    int             vmode;     // 0 always valid, 1 toggling, 2 random
    bit             noise;     // random sum_enable during FILL/STREAM
    int             resp;      // cycles after data_start for sum_enable, -1 none
    logic [SUM_W-1:0] resp_val;
    int             exp_sum;   // -1: computed from the bytes
    int             fill_min;
    int             fill_max;
  } vec_t;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] data_out;
  logic              data_start;
  logic [SUM_W-1:0]  sum_in = '0;
  logic              sum_enable = 1'b0;
  logic [SUM_W-1:0]  group_sum;
  logic [SUM_W-1:0]  result_sum;
  logic              result_valid;
  logic              timeout_err;
  logic              busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [DATA_W-1:0] grp [GL];
  vec_t              vecs [NVEC];
  logic [SUM_W-1:0]  exp_result = '0;
  int                prev_gsum  = 0;

  sum_group_source dut (
    .CLK         (CLK),
    .RST         (RST),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .data_out    (data_out),
    .data_start  (data_start),
    .sum_in      (sum_in),
    .sum_enable  (sum_enable),
    .group_sum   (group_sum),
    .result_sum  (result_sum),
    .result_valid(result_valid),
    .timeout_err (timeout_err),
    .busy        (busy)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic fill_bytes(input int pat);
    for (int i = 0; i < GL; i++) begin
      case (pat)
        P_RAMP:  grp[i] = DATA_W'(i);
        P_FF:    grp[i] = 8'hFF;
        default: grp[i] = DATA_W'($urandom);
      endcase
    end
  endtask

  // Offer the bytes of grp until all are accepted; ends in the cycle after the last accept.
  task automatic feed(input int vmode, input bit noise, output int cyc, output int acc, output int rv_seen);
    bit take;
    acc = 0; cyc = 0; rv_seen = 0;
    while (acc < GL && cyc < 4000) begin
      case (vmode)
        0:       in_valid = 1'b1;
        1:       in_valid = (cyc % 2 == 0);
        default: in_valid = ($urandom_range(2, 0) != 0);
      endcase
      in_data = grp[acc];
      if (noise) begin
        sum_enable = ($urandom_range(3, 0) == 0);
        sum_in     = SUM_W'($urandom);
      end
      take = in_valid && in_ready;
      tick();
      cyc++;
      if (take) acc++;
      if (result_valid) rv_seen++;
    end
    in_valid   = 1'b0;
    sum_enable = 1'b0;
  endtask

  task automatic do_group(input vec_t v);
    int  cyc, acc, rv_seen, exp_sum, exp_t, bad, t_rv, t_to, t_rdy, n_rv, n_to;
    bit  exp_to;
    fill_bytes(v.pat);
    exp_sum = 0;
    for (int i = 0; i < GL; i++) exp_sum += int'(grp[i]);
    if (v.exp_sum >= 0) exp_sum = v.exp_sum;

    cyc = 0;
    while (!in_ready && cyc < 600) begin tick(); cyc++; end
    if (!in_ready) begin check("ready_wait", 0, 1); return; end
    check("gsum_hold", group_sum, prev_gsum);

    feed(v.vmode, v.noise, cyc, acc, rv_seen);
    if (acc != GL) begin check("fill_done", acc, GL); return; end
    // Now in the START cycle T.
    check("fill_len", (cyc >= v.fill_min && cyc <= v.fill_max), 1);
    check("data_start", data_start, 1);
    check("start_busy_rdy", {busy, in_ready}, 2'b10);
    check("start_dout", data_out, 0);
    check("group_sum", group_sum, exp_sum);

    bad = 0;
    for (int k = 0; k < GL; k++) begin
      if (v.noise) begin
        sum_enable = ($urandom_range(3, 0) == 0);
        sum_in     = SUM_W'($urandom);
      end
      tick();
      if (data_out !== grp[k] || data_start || !busy || in_ready) bad++;
      if (result_valid) rv_seen++;
    end
    sum_enable = 1'b0;
    check("stream", bad, 0);
    check("noise_no_rv", rv_seen, 0);
    check("noise_rsum", result_sum, exp_result);

    exp_to = !(v.resp >= GL + 1 && v.resp <= GL + 1 + TIMEOUT);
    exp_t  = exp_to ? GL + 2 + TIMEOUT : v.resp + 1;
    t_rv = -1; t_to = -1; t_rdy = -1; n_rv = 0; n_to = 0; bad = 0;
    for (int d = GL + 1; d <= exp_t + 2; d++) begin
      tick();
      if (result_valid) begin n_rv++; if (t_rv < 0) t_rv = d; end
      if (timeout_err)  begin n_to++; if (t_to < 0) t_to = d; end
      if (in_ready && t_rdy < 0) t_rdy = d;
      if (data_out !== '0 || data_start) bad++;
      if ((d < exp_t) != busy) bad++;
      sum_enable = (d == v.resp);
      sum_in     = (d == v.resp) ? v.resp_val : SUM_W'($urandom);
    end
    sum_enable = 1'b0;

    if (exp_to) begin
      check("to_cycle", t_to, exp_t);
      check("to_count", n_to, 1);
      check("to_no_rv", n_rv, 0);
    end else begin
      exp_result = v.resp_val;
      check("rv_cycle", t_rv, exp_t);
      check("rv_count", n_rv, 1);
      check("rv_no_to", n_to, 0);
    end
    check("result_sum", result_sum, exp_result);
    check("ready_cycle", t_rdy, exp_t);
    check("wait_outputs", bad, 0);
    prev_gsum = exp_sum;
  endtask

  initial begin
    int cyc, acc, rv_seen;
    vec_t rv;

    vecs[0] = '{P_RAMP, 0, 1'b0, 140, 17'h1ABCD, 8128,  128, 128};
    vecs[1] = '{P_FF,   1, 1'b0, -1,  17'h00000, 32640, 255, 256};
    vecs[2] = '{P_RAND, 2, 1'b1, 200, 17'h00123, -1,    128, 4000};
    vecs[3] = '{P_RAND, 0, 1'b1, GL + 1 + TIMEOUT, 17'h0BEEF, -1, 128, 128};
    vecs[4] = '{P_RAND, 2, 1'b0, GL + 2 + TIMEOUT, 17'h1FFFF, -1, 128, 4000};
    vecs[5] = '{P_RAND, 0, 1'b0, GL + 1, 17'h05555, -1, 128, 128};
    for (int i = 6; i < NVEC; i++)
      vecs[i] = '{P_RAND, int'($urandom_range(2, 0)), 1'($urandom_range(1, 0)),
                  int'($urandom_range(GL + 1, GL + 20 + TIMEOUT)), SUM_W'($urandom),
                  -1, 128, 4000};

    // Reset state.
    #3;
    check("rst_outputs", {in_ready, data_start, result_valid, timeout_err, busy}, 0);
    check("rst_dout", data_out, 0);
    check("rst_sums", {group_sum, result_sum}, 0);
    @(posedge CLK); #1;
    RST = 1'b0;
    check("post_rst_idle", in_ready, 0);
    tick();
    check("post_rst_ready", in_ready, 1);

    for (int i = 0; i < NVEC; i++) do_group(vecs[i]);

    // Reset while stream byte 60 is on data_out.
    fill_bytes(P_RAND);
    feed(0, 1'b0, cyc, acc, rv_seen);
    check("mid_fill_done", acc, GL);
    check("mid_start", data_start, 1);
    for (int k = 0; k <= 60; k++) tick();
    check("mid_byte60", data_out, grp[60]);
    #2 RST = 1'b1;
    #1;
    check("mid_rst_dout", data_out, 0);
    check("mid_rst_ctrl", {data_start, busy, in_ready}, 0);
    check("mid_rst_sums", {group_sum, result_sum}, 0);
    exp_result = '0;
    prev_gsum  = 0;
    @(posedge CLK); #1;
    RST = 1'b0;
    check("mid_rel_idle", in_ready, 0);
    tick();
    check("mid_rel_ready", in_ready, 1);

    rv = '{P_RAND, 0, 1'b0, 150, 17'h0A5A5, -1, 128, 128};
    do_group(rv);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
